// File: rtl/id_ex_if.sv
// ID->EX bundle: decoded instruction from ID, registered EX slot back out.
// Parameters must match the id_ex_stage instance they connect to.
interface id_ex_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4
);
    logic                  id_valid;
    logic [CTRL_W-1:0]     id_alu_ctrl;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [DATA_W-1:0]     id_rs1_data;
    logic [DATA_W-1:0]     id_rs2_data;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_use_imm;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;

    logic                  ex_valid;
    logic [CTRL_W-1:0]     ex_alu_ctrl;
    logic [DATA_W-1:0]     ex_r1;
    logic [DATA_W-1:0]     ex_r2;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;

    modport master (
        output id_valid, id_alu_ctrl,
        output id_rs1_addr, id_rs2_addr,
        output id_rs1_data, id_rs2_data,
        output id_imm, id_use_imm,
        output id_rd_addr, id_reg_write,
        output id_mem_read,
        input  ex_valid, ex_alu_ctrl,
        input  ex_r1, ex_r2,
        input  ex_rd_addr, ex_reg_write,
        input  ex_mem_read
    );

    modport slave (
        input  id_valid, id_alu_ctrl,
        input  id_rs1_addr, id_rs2_addr,
        input  id_rs1_data, id_rs2_data,
        input  id_imm, id_use_imm,
        input  id_rd_addr, id_reg_write,
        input  id_mem_read,
        output ex_valid, ex_alu_ctrl,
        output ex_r1, ex_r2,
        output ex_rd_addr, ex_reg_write,
        output ex_mem_read
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Define FWD_EN for EX/MEM + MEM/WB forwarding; otherwise any RAW stalls.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_if.slave                io,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic                  exmem_reg_write,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic                  memwb_reg_write,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  load_use_stall
);
    localparam logic [CTRL_W-1:0] LAST_OP = CTRL_W'(11);

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W-1:0]     alu_ctrl;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     d1;
        logic [DATA_W-1:0]     d2;
        logic [DATA_W-1:0]     imm;
        logic                  use_imm;
        logic                  reg_write;
        logic                  mem_read;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t id_d;
    logic   legal;
    logic   rs2_live;
    logic   ex_hit;

    // Illegal opcodes become ALU op 0 and never write back.
    always_comb begin
        legal          = io.id_alu_ctrl <= LAST_OP;
        id_d           = '0;
        id_d.valid     = 1'b1;
        id_d.alu_ctrl  = legal ? io.id_alu_ctrl : '0;
        id_d.rs1       = io.id_rs1_addr;
        id_d.rs2       = io.id_rs2_addr;
        id_d.rd        = io.id_rd_addr;
        id_d.d1        = io.id_rs1_data;
        id_d.d2        = io.id_rs2_data;
        id_d.imm       = io.id_imm;
        id_d.use_imm   = io.id_use_imm;
        id_d.reg_write = io.id_reg_write & legal;
        id_d.mem_read  = io.id_mem_read;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall_in) begin
            if (load_use_stall || !io.id_valid)
                ex_q <= '0;
            else
                ex_q <= id_d;
        end
    end

    assign rs2_live = !io.id_use_imm;

    assign ex_hit = (ex_q.rd != '0) &&
                    ((io.id_rs1_addr == ex_q.rd) ||
                     (rs2_live && io.id_rs2_addr == ex_q.rd));

`ifdef FWD_EN
    logic em_rs1;
    logic em_rs2;
    logic mw_rs1;
    logic mw_rs2;

    assign load_use_stall = io.id_valid & ex_q.valid &
                            ex_q.mem_read & ex_hit;

    assign em_rs1 = exmem_reg_write && (exmem_rd_addr != '0) &&
                    (exmem_rd_addr == ex_q.rs1);
    assign em_rs2 = exmem_reg_write && (exmem_rd_addr != '0) &&
                    (exmem_rd_addr == ex_q.rs2);
    assign mw_rs1 = memwb_reg_write && (memwb_rd_addr != '0) &&
                    (memwb_rd_addr == ex_q.rs1);
    assign mw_rs2 = memwb_reg_write && (memwb_rd_addr != '0) &&
                    (memwb_rd_addr == ex_q.rs2);

    // Younger producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        io.ex_r1 = ex_q.d1;
        if (em_rs1)
            io.ex_r1 = exmem_result;
        else if (mw_rs1)
            io.ex_r1 = memwb_result;
    end

    always_comb begin
        io.ex_r2 = ex_q.d2;
        if (ex_q.use_imm)
            io.ex_r2 = ex_q.imm;
        else if (em_rs2)
            io.ex_r2 = exmem_result;
        else if (mw_rs2)
            io.ex_r2 = memwb_result;
    end
`else
    logic mem_hit;
    logic unused_fwd;

    // Without bypass paths every RAW on EX or EX/MEM must wait.
    assign mem_hit = exmem_reg_write && (exmem_rd_addr != '0) &&
                     ((io.id_rs1_addr == exmem_rd_addr) ||
                      (rs2_live && io.id_rs2_addr == exmem_rd_addr));

    assign load_use_stall = io.id_valid &
                            ((ex_q.valid & ex_q.reg_write & ex_hit) |
                             mem_hit);

    assign io.ex_r1 = ex_q.d1;
    assign io.ex_r2 = ex_q.use_imm ? ex_q.imm : ex_q.d2;

    assign unused_fwd = ^{exmem_result, memwb_rd_addr,
                          memwb_reg_write, memwb_result,
                          ex_q.rs1, ex_q.rs2};
`endif

    assign io.ex_valid     = ex_q.valid;
    assign io.ex_alu_ctrl  = ex_q.alu_ctrl;
    assign io.ex_rd_addr   = ex_q.rd;
    assign io.ex_reg_write = ex_q.reg_write;
    assign io.ex_mem_read  = ex_q.mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed hazard
// sequences and a randomized run against a rule-level reference model.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        flush;
    logic [4:0]  exmem_rd_addr;
    logic        exmem_reg_write;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd_addr;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;
    logic        load_use_stall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_ex_if #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(4)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .io              (bus),
        .stall_in        (stall_in),
        .flush           (flush),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .load_use_stall  (load_use_stall)
    );

    always #5 clk = ~clk;

    // Expected content of the EX slot.
    typedef struct {
        bit        valid;
        bit [3:0]  ctrl;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [4:0]  rd;
        bit [31:0] d1;
        bit [31:0] d2;
        bit [31:0] imm;
        bit        use_imm;
        bit        rw;
        bit        mr;
    } slot_t;

    typedef struct {
        bit        v;
        bit [3:0]  ctrl;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [4:0]  rd;
        bit [31:0] d1;
        bit [31:0] d2;
        bit [31:0] imm;
        bit        ui;
        bit        rw;
        bit        mr;
        bit        e_v;
        bit [3:0]  e_ctrl;
        bit [31:0] e_r1;
        bit [31:0] e_r2;
        bit        e_rw;
        bit        e_mr;
        bit [4:0]  e_rd;
    } vec_t;

    slot_t m;
    vec_t  tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit reads(input bit [4:0] r);
        return r != 0 &&
               (bus.id_rs1_addr == r ||
                (!bus.id_use_imm && bus.id_rs2_addr == r));
    endfunction

    function automatic bit exp_lus();
`ifdef FWD_EN
        return bus.id_valid && m.valid && m.mr && reads(m.rd);
`else
        return bus.id_valid &&
               ((m.valid && m.rw && reads(m.rd)) ||
                (exmem_reg_write && reads(exmem_rd_addr)));
`endif
    endfunction

    function automatic bit [31:0] fwd(input bit [4:0] r, input bit [31:0] rf);
`ifdef FWD_EN
        if (exmem_reg_write && exmem_rd_addr != 0 && exmem_rd_addr == r)
            return exmem_result;
        if (memwb_reg_write && memwb_rd_addr != 0 && memwb_rd_addr == r)
            return memwb_result;
`endif
        return rf;
    endfunction

    function automatic slot_t next_slot();
        slot_t n;
        n = '{default: 0};
        if (rst || flush)
            return n;
        if (stall_in)
            return m;
        if (exp_lus() || !bus.id_valid)
            return n;
        n.valid   = 1;
        n.ctrl    = bus.id_alu_ctrl > 11 ? 4'd0 : bus.id_alu_ctrl;
        n.rw      = bus.id_alu_ctrl > 11 ? 1'b0 : bus.id_reg_write;
        n.rs1     = bus.id_rs1_addr;
        n.rs2     = bus.id_rs2_addr;
        n.rd      = bus.id_rd_addr;
        n.d1      = bus.id_rs1_data;
        n.d2      = bus.id_rs2_data;
        n.imm     = bus.id_imm;
        n.use_imm = bus.id_use_imm;
        n.mr      = bus.id_mem_read;
        return n;
    endfunction

    task automatic check_out();
        chk("ex_valid", bus.ex_valid, m.valid);
        chk("ex_alu_ctrl", bus.ex_alu_ctrl, m.ctrl);
        chk("ex_rd_addr", bus.ex_rd_addr, m.rd);
        chk("ex_reg_write", bus.ex_reg_write, m.rw);
        chk("ex_mem_read", bus.ex_mem_read, m.mr);
        if (m.valid) begin
            chk("ex_r1", bus.ex_r1, fwd(m.rs1, m.d1));
            chk("ex_r2", bus.ex_r2,
                m.use_imm ? m.imm : fwd(m.rs2, m.d2));
        end
    endtask

    task automatic tick();
        slot_t nx;
        #1;
        chk("load_use_stall", load_use_stall, exp_lus());
        nx = next_slot();
        @(posedge clk);
        m = nx;
        #1;
        check_out();
    endtask

    task automatic set_id(input bit v, input bit [3:0] c,
                          input bit [4:0] a1, a2, d,
                          input bit [31:0] x1, x2, im,
                          input bit ui, rw, mr);
        bus.id_valid     = v;
        bus.id_alu_ctrl  = c;
        bus.id_rs1_addr  = a1;
        bus.id_rs2_addr  = a2;
        bus.id_rd_addr   = d;
        bus.id_rs1_data  = x1;
        bus.id_rs2_data  = x2;
        bus.id_imm       = im;
        bus.id_use_imm   = ui;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic clr_fwd();
        exmem_rd_addr   = 0;
        exmem_reg_write = 0;
        exmem_result    = 0;
        memwb_rd_addr   = 0;
        memwb_reg_write = 0;
        memwb_result    = 0;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst      = 1;
        stall_in = 0;
        flush    = 0;
        clr_fwd();
        set_id(1, 1, 1, 2, 3, 5, 7, 0, 0, 1, 0);

        // Reset: one edge clears the slot even with a valid ID op.
        @(posedge clk);
        m = '{default: 0};
        #1;
        chk("rst_valid", bus.ex_valid, 1'b0);
        chk("rst_ctrl", bus.ex_alu_ctrl, 4'd0);
        chk("rst_rw", bus.ex_reg_write, 1'b0);
        rst = 0;

        tbl[0] = '{1, 1, 1, 2, 3, 5, 7, 0, 0, 1, 0,
                   1, 1, 5, 7, 1, 0, 3};
        tbl[1] = '{1, 2, 5, 6, 7, 100, 200, 32'hFFFF_FFFC, 1, 1, 0,
                   1, 2, 100, 32'hFFFF_FFFC, 1, 0, 7};
        tbl[2] = '{1, 13, 1, 2, 8, 9, 10, 0, 0, 1, 0,
                   1, 0, 9, 10, 0, 0, 8};
        tbl[3] = '{1, 15, 3, 4, 9, 1, 2, 0, 0, 1, 0,
                   1, 0, 1, 2, 0, 0, 9};
        tbl[4] = '{1, 11, 3, 4, 9, 1, 2, 0, 0, 1, 0,
                   1, 11, 1, 2, 1, 0, 9};
        tbl[5] = '{1, 12, 3, 4, 9, 1, 2, 0, 0, 1, 1,
                   1, 0, 1, 2, 0, 1, 9};
        tbl[6] = '{0, 5, 1, 2, 6, 3, 3, 0, 0, 1, 1,
                   0, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 10, 0, 4, 32'h1000, 0, 8, 1, 1, 1,
                   1, 1, 32'h1000, 8, 1, 1, 4};

        for (int i = 0; i < 8; i++) begin
            set_id(tbl[i].v, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2,
                   tbl[i].rd, tbl[i].d1, tbl[i].d2, tbl[i].imm,
                   tbl[i].ui, tbl[i].rw, tbl[i].mr);
            tick();
            chk($sformatf("vec%0d_valid", i), bus.ex_valid, tbl[i].e_v);
            chk($sformatf("vec%0d_ctrl", i), bus.ex_alu_ctrl, tbl[i].e_ctrl);
            chk($sformatf("vec%0d_rw", i), bus.ex_reg_write, tbl[i].e_rw);
            chk($sformatf("vec%0d_mr", i), bus.ex_mem_read, tbl[i].e_mr);
            chk($sformatf("vec%0d_rd", i), bus.ex_rd_addr, tbl[i].e_rd);
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d_r1", i), bus.ex_r1, tbl[i].e_r1);
                chk($sformatf("vec%0d_r2", i), bus.ex_r2, tbl[i].e_r2);
            end
            idle();
        end

        // Forwarding priority and the x0 rule.
        set_id(1, 1, 1, 0, 2, 32'h99, 3, 0, 0, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exmem_rd_addr   = 1;
        exmem_reg_write = 1;
        exmem_result    = 32'h10;
        memwb_rd_addr   = 1;
        memwb_reg_write = 1;
        memwb_result    = 32'h20;
        #1;
`ifdef FWD_EN
        chk("fwd_exmem", bus.ex_r1, 32'h10);
`else
        chk("nofwd_exmem", bus.ex_r1, 32'h99);
`endif
        exmem_reg_write = 0;
        #1;
`ifdef FWD_EN
        chk("fwd_memwb", bus.ex_r1, 32'h20);
`else
        chk("nofwd_memwb", bus.ex_r1, 32'h99);
`endif
        clr_fwd();
        set_id(1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        tick();
        exmem_reg_write = 1;
        exmem_result    = 32'h55;
        memwb_reg_write = 1;
        memwb_result    = 32'h66;
        #1;
        chk("x0_no_fwd_r1", bus.ex_r1, 32'h0);
        chk("x0_no_fwd_r2", bus.ex_r2, 32'h0);
        clr_fwd();
        idle();

        // Load-use: LW r4 in EX, consumer of r4 in ID.
        set_id(1, 1, 10, 0, 4, 0, 0, 8, 1, 1, 1);
        tick();
        set_id(1, 1, 4, 5, 6, 32'h777, 1, 0, 0, 1, 0);
        #1;
        chk("lus_set", load_use_stall, 1'b1);
        tick();
        chk("lus_bubble", bus.ex_valid, 1'b0);
        memwb_rd_addr   = 4;
        memwb_reg_write = 1;
        memwb_result    = 32'hABCD;
        #1;
        chk("lus_clear", load_use_stall, 1'b0);
        tick();
        chk("lus_resume", bus.ex_valid, 1'b1);
`ifdef FWD_EN
        chk("lus_fwd_r1", bus.ex_r1, 32'hABCD);
`else
        chk("lus_rf_r1", bus.ex_r1, 32'h777);
`endif
        clr_fwd();
        idle();

        // stall_in holds for 3 cycles, then flush beats stall.
        set_id(1, 3, 7, 8, 11, 32'h1234, 5, 0, 0, 1, 0);
        tick();
        stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 4'($urandom_range(0, 11)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(1, 3)),
                   $urandom, $urandom, $urandom, 0, 1, 0);
            tick();
            chk("stall_hold_rd", bus.ex_rd_addr, 5'd11);
            chk("stall_hold_r1", bus.ex_r1, 32'h1234);
            chk("stall_hold_ctrl", bus.ex_alu_ctrl, 4'd3);
        end
        flush = 1;
        tick();
        chk("flush_over_stall", bus.ex_valid, 1'b0);
        flush    = 0;
        stall_in = 0;
        idle();

        // RAW against EX/MEM only stalls without bypass paths.
        exmem_rd_addr   = 5;
        exmem_reg_write = 1;
        set_id(1, 1, 5, 0, 6, 0, 0, 0, 0, 1, 0);
        #1;
`ifdef FWD_EN
        chk("exmem_raw_nostall", load_use_stall, 1'b0);
`else
        chk("exmem_raw_stall", load_use_stall, 1'b1);
`endif
        tick();
        clr_fwd();
        idle();

        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 49) == 0);
            flush           = ($urandom_range(0, 9) == 0);
            stall_in        = ($urandom_range(0, 5) == 0);
            set_id(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   1'($urandom), 1'($urandom), 1'($urandom));
            exmem_rd_addr   = 5'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom);
            exmem_result    = $urandom;
            memwb_rd_addr   = 5'($urandom_range(0, 3));
            memwb_reg_write = 1'($urandom);
            memwb_result    = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
